pipeline_mux_arbiter: RTL and testbench
=======================================

Name: pipeline_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 5-bit, 4-input pipeline select mux, e.g. register-file write-address or forwarding-source selection.
- Accepts requests from four pipeline sources and picks one per transfer.
- Drives the 2-bit mux select and a registered copy of the chosen address.
- Presents the result downstream through a valid/ready handshake, with back-pressure and fair rotation.

Parameters:
- AW, 5: address/data width of each mux input and of the output.
- DROP_ZERO, 1: when 1, a granted request whose address is 0 ($zero) is acknowledged but never presented downstream.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  4  per-source request; bit i belongs to input ci
- c0  in  AW  source 0 address
- c1  in  AW  source 1 address
- c2  in  AW  source 2 address
- c3  in  AW  source 3 address
- gnt  out  4  one-hot, one-cycle grant acknowledge (registered)
- sel  out  2  mux select of the current/last transfer (registered)
- y  out  AW  selected address (registered), valid when out_valid=1
- out_valid  out  1  downstream data valid
- out_ready  in  1  downstream accepts y this cycle

Behaviour:
- Reset (reset=1 at a clock edge):
  - gnt=0, sel=0, y=0, out_valid=0.
  - Round-robin pointer ptr=0.
  - Reset overrides everything. Reset mid-transfer discards the held y with no gnt re-issue.
- Load condition: load = !out_valid | out_ready.
- Effective requests: ereq = req & ~gnt.
  - A source granted in the previous cycle is masked for one cycle so it can drop req.
- Winner:
  - The first set bit of ereq searching from ptr upward, modulo 4 (ptr, ptr+1, ptr+2, ptr+3).
  - Purely combinational; no state beyond ptr.
- On a clock edge with load=1 and ereq!=0, winner w:
  - gnt <= one-hot(w); sel <= w; y <= cw; ptr <= w+1 mod 4.
  - out_valid <= 1, except when DROP_ZERO=1 and cw==0; then out_valid <= 0 and y <= 0. The gnt is still issued.
- On a clock edge with load=1 and ereq==0:
  - gnt <= 0; out_valid <= 0.
  - sel, y and ptr hold.
- On a clock edge with load=0 (out_valid=1, out_ready=0):
  - gnt <= 0.
  - sel, y, out_valid and ptr hold.
  - No new winner is chosen; requests wait.
- Latency:
  - Request to gnt/out_valid is 1 cycle when load=1.
  - Back-to-back transfers sustain 1 per cycle when out_ready stays 1 and different sources are requesting.
  - A single source re-requesting continuously gets at most 1 grant per 2 cycles because of the mask.
- Simultaneous events: when out_valid & out_ready and new requests arrive in the same cycle, the new winner loads on that edge. There is no bubble.
- Requester contract: hold req and a stable cw until gnt is seen; deassert or present a new request the cycle after. Violations are not checked.
- Pointer wrap: w=3 gives ptr=0.
- Internal FSM, 2 states:
  - IDLE (out_valid=0) goes to BUSY on a non-dropped grant.
  - BUSY (out_valid=1) stays on stall.
  - BUSY on accept goes to BUSY on a new grant, or to IDLE.

Decomposition:
- Shared package:
  - AW default.
  - Number of sources (4) and select width (2).
  - Localparam state encodings IDLE=1'b0, BUSY=1'b1.
- One sub-module: pipeline_rr_pick, a combinational 4-way rotate-priority encoder (ereq, ptr → w, any). It is instantiated once.
- The data path reuses the team's existing 4:1 select mux, driven by the registered sel.

Test Plan:
- Reset and idle: hold reset 2 cycles with req=4'b1111 → gnt=0, out_valid=0, sel=0, y=0. Release with out_ready=1 → next cycle gnt=0001, sel=0, y=c0.
- Rotation: req=1111 held, out_ready=1, c0..c3=5,6,7,8 → grants 0001,0010,0100,1000,0001 on successive cycles; y=5,6,7,8,5.
- Back-pressure: grant source 2 (c2=9), out_ready=0 for 3 cycles while req=0011 → y=9, sel=2 stable, gnt=0 during stall. On out_ready=1, the next edge grants 0001 (ptr=3 wraps to 0).
- Zero drop: DROP_ZERO=1, req=0010, c1=0 → gnt=0010 for one cycle, out_valid stays 0, ptr becomes 2. Repeat with DROP_ZERO=0 → out_valid=1, y=0.
- Self-mask: only req[3]=1, held continuously, out_ready=1 → gnt[3] pulses every other cycle; out_valid alternates 1/0.
- Reset mid-transfer: out_valid=1, out_ready=0, assert reset 1 cycle → out_valid=0, ptr=0. With req=1111 the next grant is 0001.

Source files
------------

// File: rtl/pipeline_mux_arbiter_pkg.sv
// Shared constants for the pipeline select-mux arbiter.
package pipeline_mux_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int N_SRC  = 4;
  localparam int SEL_W  = 2;

  // FSM encodings: IDLE means nothing is presented downstream.
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

endpackage

// File: rtl/pipeline_mux_arbiter_pick.sv
// Combinational 4-way rotate-priority encoder: first set bit of ereq at or
// after ptr, wrapping modulo 4.
module pipeline_rr_pick
  import pipeline_mux_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] ereq,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] w,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit is kept last.
  always_comb begin
    w   = ptr;
    any = 1'b0;
    idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (ereq[idx]) begin
        w   = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_mux_arbiter.sv
// Round-robin arbiter for the shared 4-input pipeline select mux, presenting
// the chosen address downstream through a valid/ready handshake.
//
// Handshake: y is transferred on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, y/sel/out_valid hold and no
// new winner is chosen. A new winner may load on the same edge as an accept.
module pipeline_mux_arbiter
  import pipeline_mux_arbiter_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DROP_ZERO = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic [AW-1:0]    c0,
  input  logic [AW-1:0]    c1,
  input  logic [AW-1:0]    c2,
  input  logic [AW-1:0]    c3,
  output logic [N_SRC-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic [AW-1:0]    y,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [AW-1:0]    y_q, y_d;
  logic             state_q, state_d;

  logic             load;
  logic [N_SRC-1:0] ereq;
  logic [SEL_W-1:0] win;
  logic             win_any;
  logic [AW-1:0]    cw;

  // A source granted last cycle is masked for one cycle so it can drop req.
  assign ereq = req & ~gnt_q;
  assign load = (state_q == IDLE) | out_ready;

  pipeline_rr_pick u_pick (
    .ereq (ereq),
    .ptr  (ptr_q),
    .w    (win),
    .any  (win_any)
  );

  // 4:1 select of the winning source address.
  always_comb begin
    cw = c0;
    case (win)
      2'd0: cw = c0;
      2'd1: cw = c1;
      2'd2: cw = c2;
      2'd3: cw = c3;
      default: cw = c0;
    endcase
  end

  // Next-state: grant, pointer rotation, held output and FSM.
  always_comb begin
    gnt_d   = '0;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    state_d = state_q;
    if (load) begin
      if (win_any) begin
        gnt_d = N_SRC'(1) << win;
        sel_d = win;
        ptr_d = win + SEL_W'(1);
        if ((DROP_ZERO != 0) && (cw == '0)) begin
          // $zero target: acknowledge the source but present nothing.
          y_d     = '0;
          state_d = IDLE;
        end else begin
          y_d     = cw;
          state_d = BUSY;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      y_q     <= '0;
      state_q <= IDLE;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      state_q <= state_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign y         = y_q;
  assign out_valid = (state_q == BUSY);

endmodule

// File: tb/tb_pipeline_mux_arbiter.sv
// Directed bench for pipeline_mux_arbiter: a vector table walked in a loop
// plus hand sequences for reset mid-transfer and DROP_ZERO=0 behaviour.
module tb_pipeline_mux_arbiter;

  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic [AW-1:0] c0, c1, c2, c3;
  logic          out_ready;

  logic [3:0]    gnt, gnt_nz;
  logic [1:0]    sel, sel_nz;
  logic [AW-1:0] y, y_nz;
  logic          out_valid, out_valid_nz;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_mux_arbiter #(.AW(AW), .DROP_ZERO(1)) dut (
    .clk(clk), .reset(reset), .req(req),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .gnt(gnt), .sel(sel), .y(y), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  pipeline_mux_arbiter #(.AW(AW), .DROP_ZERO(0)) dut_nz (
    .clk(clk), .reset(reset), .req(req),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .gnt(gnt_nz), .sel(sel_nz), .y(y_nz), .out_valid(out_valid_nz),
    .out_ready(out_ready)
  );

  typedef struct {
    logic          rst;
    logic [3:0]    req;
    logic [AW-1:0] c0, c1, c2, c3;
    logic          rdy;
    logic [3:0]    e_gnt;
    logic [1:0]    e_sel;
    logic [AW-1:0] e_y;
    logic          e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] rq,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                              input logic rdy, input logic [3:0] eg,
                              input logic [1:0] es, input logic [AW-1:0] ey,
                              input logic ev);
    vec_t v;
    v.rst = rst; v.req = rq; v.c0 = a0; v.c1 = a1; v.c2 = a2; v.c3 = a3;
    v.rdy = rdy; v.e_gnt = eg; v.e_sel = es; v.e_y = ey; v.e_valid = ev;
    vecs.push_back(v);
  endfunction

  // Driver tasks
  task automatic drive(input logic rst, input logic [3:0] rq,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                       input logic rdy);
    reset = rst; req = rq; c0 = a0; c1 = a1; c2 = a2; c3 = a3; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_main(input int idx, input logic [3:0] eg,
                            input logic [1:0] es, input logic [AW-1:0] ey,
                            input logic ev);
    check("gnt", idx, 8'(gnt), 8'(eg));
    check("sel", idx, 8'(sel), 8'(es));
    check("y", idx, 8'(y), 8'(ey));
    check("out_valid", idx, 8'(out_valid), 8'(ev));
  endtask

  initial begin
    drive(1'b1, 4'b0000, '0, '0, '0, '0, 1'b1);

    // Reset held two cycles with all requests up.
    add(1, 4'b1111, 5, 6, 7, 8, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 5, 6, 7, 8, 1, 4'b0000, 0, 0, 0);
    // Rotation 0,1,2,3,0.
    add(0, 4'b1111, 5, 6, 7, 8, 1, 4'b0001, 0, 5, 1);
    add(0, 4'b1111, 5, 6, 7, 8, 1, 4'b0010, 1, 6, 1);
    add(0, 4'b1111, 5, 6, 7, 8, 1, 4'b0100, 2, 7, 1);
    add(0, 4'b1111, 5, 6, 7, 8, 1, 4'b1000, 3, 8, 1);
    add(0, 4'b1111, 5, 6, 7, 8, 1, 4'b0001, 0, 5, 1);
    // Grant source 2 with c2=9, then stall three cycles.
    add(0, 4'b0100, 5, 6, 9, 8, 1, 4'b0100, 2, 9, 1);
    add(0, 4'b0011, 5, 6, 9, 8, 0, 4'b0000, 2, 9, 1);
    add(0, 4'b0011, 5, 6, 9, 8, 0, 4'b0000, 2, 9, 1);
    add(0, 4'b0011, 5, 6, 9, 8, 0, 4'b0000, 2, 9, 1);
    // Release: ptr=3 wraps, source 0 wins.
    add(0, 4'b0011, 5, 6, 9, 8, 1, 4'b0001, 0, 5, 1);
    add(0, 4'b0000, 5, 6, 9, 8, 1, 4'b0000, 0, 5, 0);
    // Zero drop on source 1: grant issued, nothing presented.
    add(0, 4'b0010, 5, 0, 7, 8, 1, 4'b0010, 1, 0, 0);
    add(0, 4'b0000, 5, 0, 7, 8, 1, 4'b0000, 1, 0, 0);
    // ptr advanced to 2 by the dropped grant: source 0 beats source 1.
    add(0, 4'b0011, 5, 6, 7, 8, 1, 4'b0001, 0, 5, 1);
    // Self-mask: lone requester 3 granted every other cycle.
    add(0, 4'b1000, 5, 6, 7, 8, 1, 4'b1000, 3, 8, 1);
    add(0, 4'b1000, 5, 6, 7, 8, 1, 4'b0000, 3, 8, 0);
    add(0, 4'b1000, 5, 6, 7, 8, 1, 4'b1000, 3, 8, 1);
    add(0, 4'b1000, 5, 6, 7, 8, 1, 4'b0000, 3, 8, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].c0, vecs[i].c1,
            vecs[i].c2, vecs[i].c3, vecs[i].rdy);
      step();
      check_main(i, vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_y, vecs[i].e_valid);
    end

    // Reset mid-transfer: grant source 2 (ptr -> 3), stall, then reset.
    drive(0, 4'b0100, 5, 6, 7, 8, 0);
    step();
    check_main(100, 4'b0100, 2, 7, 1);
    drive(0, 4'b0000, 5, 6, 7, 8, 0);
    step();
    check_main(101, 4'b0000, 2, 7, 1);
    drive(1, 4'b1111, 5, 6, 7, 8, 0);
    step();
    check_main(102, 4'b0000, 0, 0, 0);
    // ptr was reset to 0, so source 0 wins rather than source 3.
    drive(0, 4'b1111, 5, 6, 7, 8, 1);
    step();
    check_main(103, 4'b0001, 0, 5, 1);

    // Zero address with DROP_ZERO=0 is presented; DROP_ZERO=1 drops it.
    drive(0, 4'b0010, 5, 0, 7, 8, 1);
    step();
    check_main(104, 4'b0010, 1, 0, 0);
    check("nz_gnt", 104, 8'(gnt_nz), 8'(4'b0010));
    check("nz_sel", 104, 8'(sel_nz), 8'(2'd1));
    check("nz_y", 104, 8'(y_nz), 8'(0));
    check("nz_out_valid", 104, 8'(out_valid_nz), 8'(1));
    drive(0, 4'b0000, 5, 6, 7, 8, 1);
    step();
    check("nz_out_valid", 105, 8'(out_valid_nz), 8'(0));
    check("nz_gnt", 105, 8'(gnt_nz), 8'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
